ecc_secded_dec_stat: RTL and testbench

ECC_SECDED_DEC_STAT -- requirements
Module: ecc_secded_dec_stat

---
 rtl/ecc_secded_dec_stat.sv | 155 +++++++++++++++
 tb/tb_ecc_secded_dec_stat.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_secded_dec_stat.sv
// ecc_secded_dec_stat: extended-Hamming SECDED decoder with correction statistics.
// Pipeline stages: capture -> syndrome/parity -> correct/extract.
// Optional build macro ECC_SECDED_ERR_INJECT_EN adds an inj_mask input that is
// XORed into the received symbol at capture.
module ecc_secded_dec_stat #(
    parameter int DAT_WIDTH = 33,
    parameter int CNT_WIDTH = 16,
    // Smallest r with 2^r >= DAT_WIDTH+r+1 (valid for DAT_WIDTH 4..120), plus overall parity.
    localparam int PAR_WIDTH = ((2**3 >= DAT_WIDTH + 4) ? 3 :
                                (2**4 >= DAT_WIDTH + 5) ? 4 :
                                (2**5 >= DAT_WIDTH + 6) ? 5 :
                                (2**6 >= DAT_WIDTH + 7) ? 6 : 7) + 1,
    localparam int SYM_WIDTH = DAT_WIDTH + PAR_WIDTH
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 din_valid,
    input  logic [SYM_WIDTH-1:0] din,
`ifdef ECC_SECDED_ERR_INJECT_EN
    input  logic [SYM_WIDTH-1:0] inj_mask,
`endif
    output logic                 dout_valid,
    output logic [DAT_WIDTH-1:0] dout,
    output logic                 dout_err,
    output logic                 dout_fail,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] corr_cnt,
    output logic [CNT_WIDTH-1:0] fail_cnt
);

    localparam int SYN_WIDTH = PAR_WIDTH - 1;
    localparam logic [SYN_WIDTH-1:0] MAX_IDX = SYN_WIDTH'(SYM_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [SYM_WIDTH-1:0] din_cap;
    logic                 s1_valid;
    logic [SYM_WIDTH-1:0] s1_sym;
    logic [SYN_WIDTH-1:0] syn_c;
    logic                 par_c;
    logic                 s2_valid;
    logic [SYM_WIDTH-1:0] s2_sym;
    logic [SYN_WIDTH-1:0] s2_syn;
    logic                 s2_par;
    logic                 clean_c;
    logic                 single_c;
    logic                 fail_c;
    logic [SYM_WIDTH-1:0] flip_c;
    logic [SYM_WIDTH-1:0] corr_sym_c;
    logic [DAT_WIDTH-1:0] data_c;

`ifdef ECC_SECDED_ERR_INJECT_EN
    assign din_cap = din ^ inj_mask;
`else
    assign din_cap = din;
`endif

    // Stage 1: capture the received symbol.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s1_valid <= 1'b0;
            s1_sym   <= '0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) begin
                s1_sym <= din_cap;
            end
        end
    end

    // Syndrome is the XOR of the indices of all set bits above the overall-parity bit.
    always_comb begin
        syn_c = '0;
        for (int i = 1; i < SYM_WIDTH; i++) begin
            if (s1_sym[i]) begin
                syn_c = syn_c ^ SYN_WIDTH'(i);
            end
        end
        par_c = ^s1_sym;
    end

    // Stage 2: register syndrome and overall parity alongside the raw symbol.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s2_valid <= 1'b0;
            s2_sym   <= '0;
            s2_syn   <= '0;
            s2_par   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sym <= s1_sym;
                s2_syn <= syn_c;
                s2_par <= par_c;
            end
        end
    end

    // Classify, flip the single bad bit if there is one, then pull payload bits out.
    // Uncorrectable symbols get no flip, so the raw payload bits pass through.
    always_comb begin
        int k;
        clean_c  = !s2_par && (s2_syn == '0);
        single_c = s2_par && (s2_syn <= MAX_IDX);
        fail_c   = !clean_c && !single_c;
        flip_c   = '0;
        for (int i = 0; i < SYM_WIDTH; i++) begin
            flip_c[i] = single_c && (s2_syn == SYN_WIDTH'(i));
        end
        corr_sym_c = s2_sym ^ flip_c;
        data_c     = '0;
        k          = 0;
        for (int i = 3; i < SYM_WIDTH; i++) begin
            if ((i & (i - 1)) != 0) begin
                data_c[k] = corr_sym_c[i];
                k         = k + 1;
            end
        end
    end

    // Stage 3: result registers; they hold their last value across bubbles.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            dout_valid <= 1'b0;
            dout       <= '0;
            dout_err   <= 1'b0;
            dout_fail  <= 1'b0;
        end else begin
            dout_valid <= s2_valid;
            if (s2_valid) begin
                dout      <= data_c;
                dout_err  <= !clean_c;
                dout_fail <= fail_c;
            end
        end
    end

    // Saturating statistics counters fed from the registered result; clear wins.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            corr_cnt <= '0;
            fail_cnt <= '0;
        end else if (cnt_clear) begin
            corr_cnt <= '0;
            fail_cnt <= '0;
        end else if (dout_valid) begin
            if (dout_err && !dout_fail && (corr_cnt != '1)) begin
                corr_cnt <= corr_cnt + CNT_ONE;
            end
            if (dout_fail && (fail_cnt != '1)) begin
                fail_cnt <= fail_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ecc_secded_dec_stat.sv
// tb_ecc_secded_dec_stat: randomized self-checking bench for ecc_secded_dec_stat.
// Expected results come from the number of flipped bits applied to a bench-encoded
// codeword; a 3-deep expectation pipe models the latency.
module tb_ecc_secded_dec_stat;

    localparam int DW = 33;
    localparam int SW = 40;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          e;
        logic          f;
    } ent_t;

    logic          clk = 1'b0;
    logic          arst;
    logic          din_valid;
    logic [SW-1:0] din;
`ifdef ECC_SECDED_ERR_INJECT_EN
    logic [SW-1:0] inj_mask;
`endif
    logic          cnt_clear;
    logic          cnt_clear_4;

    logic          dout_valid, dout_err, dout_fail;
    logic [DW-1:0] dout;
    logic [15:0]   corr_cnt, fail_cnt;
    logic          dout_valid_4, dout_err_4, dout_fail_4;
    logic [DW-1:0] dout_4;
    logic [3:0]    corr_cnt_4, fail_cnt_4;

    ecc_secded_dec_stat #(.DAT_WIDTH(DW), .CNT_WIDTH(16)) u_dut (
        .clk       (clk),
        .arst      (arst),
        .din_valid (din_valid),
        .din       (din),
`ifdef ECC_SECDED_ERR_INJECT_EN
        .inj_mask  (inj_mask),
`endif
        .dout_valid(dout_valid),
        .dout      (dout),
        .dout_err  (dout_err),
        .dout_fail (dout_fail),
        .cnt_clear (cnt_clear),
        .corr_cnt  (corr_cnt),
        .fail_cnt  (fail_cnt)
    );

    ecc_secded_dec_stat #(.DAT_WIDTH(DW), .CNT_WIDTH(4)) u_dut_4 (
        .clk       (clk),
        .arst      (arst),
        .din_valid (din_valid),
        .din       (din),
`ifdef ECC_SECDED_ERR_INJECT_EN
        .inj_mask  (inj_mask),
`endif
        .dout_valid(dout_valid_4),
        .dout      (dout_4),
        .dout_err  (dout_err_4),
        .dout_fail (dout_fail_4),
        .cnt_clear (cnt_clear_4),
        .corr_cnt  (corr_cnt_4),
        .fail_cnt  (fail_cnt_4)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_bad = 0;
    string ph = "init";

    ent_t          pipe [3];
    logic          m_dv, m_err, m_fail;
    logic [DW-1:0] m_dout;
    int            m_corr, m_fcnt, m_corr_4, m_fcnt_4;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h expected %0h", ph, tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] encode(input logic [DW-1:0] d);
        logic [SW-1:0] w;
        int j;
        w = '0;
        j = 0;
        for (int i = 3; i < SW; i++) begin
            if ((i & (i - 1)) != 0) begin
                w[i] = d[j];
                j++;
            end
        end
        for (int k = 0; (1 << k) < SW; k++) begin
            logic p;
            p = 1'b0;
            for (int i = 1; i < SW; i++) begin
                if (((i >> k) & 1) == 1) p = p ^ w[i];
            end
            w[1 << k] = p;
        end
        w[0] = ^w;
        return w;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [SW-1:0] w);
        logic [DW-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 3; i < SW; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = w[i];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_pay();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    function automatic logic [SW-1:0] bit_mask(input int a);
        logic [SW-1:0] m;
        m = '0;
        m[a] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, d: '0, e: 1'b0, f: 1'b0};
        m_dv = 1'b0; m_err = 1'b0; m_fail = 1'b0; m_dout = '0;
        m_corr = 0; m_fcnt = 0; m_corr_4 = 0; m_fcnt_4 = 0;
    endtask

    task automatic check_all();
        chk("dout_valid", 64'(dout_valid), 64'(m_dv));
        chk("dout", 64'(dout), 64'(m_dout));
        chk("dout_err", 64'(dout_err), 64'(m_err));
        chk("dout_fail", 64'(dout_fail), 64'(m_fail));
        chk("corr_cnt", 64'(corr_cnt), 64'(m_corr));
        chk("fail_cnt", 64'(fail_cnt), 64'(m_fcnt));
        chk("dout_valid_4", 64'(dout_valid_4), 64'(m_dv));
        chk("dout_4", 64'(dout_4), 64'(m_dout));
        chk("corr_cnt_4", 64'(corr_cnt_4), 64'(m_corr_4));
        chk("fail_cnt_4", 64'(fail_cnt_4), 64'(m_fcnt_4));
    endtask

    // One clock: drive inputs, advance the model, check #1 after the edge.
    task automatic step(input logic v, input logic [DW-1:0] pay, input logic [SW-1:0] emask,
                        input logic [SW-1:0] imask, input logic clr, input logic clr_4);
        logic [SW-1:0] tot;
        ent_t ne;
        int nf;
        din         = encode(pay) ^ emask;
        din_valid   = v;
        cnt_clear   = clr;
        cnt_clear_4 = clr_4;
`ifdef ECC_SECDED_ERR_INJECT_EN
        inj_mask = imask;
        tot      = emask ^ imask;
`else
        tot      = emask ^ (imask & '0);
`endif
        nf   = $countones(tot);
        ne.v = v;
        ne.e = (nf != 0);
        ne.f = (nf >= 2);
        ne.d = (nf >= 2) ? extract(encode(pay) ^ tot) : pay;
        @(posedge clk);
        if (clr) begin
            m_corr = 0; m_fcnt = 0;
        end else if (m_dv) begin
            if (m_err && !m_fail && m_corr < 65535) m_corr++;
            if (m_fail && m_fcnt < 65535) m_fcnt++;
        end
        if (clr_4) begin
            m_corr_4 = 0; m_fcnt_4 = 0;
        end else if (m_dv) begin
            if (m_err && !m_fail && m_corr_4 < 15) m_corr_4++;
            if (m_fail && m_fcnt_4 < 15) m_fcnt_4++;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = ne;
        m_dv = pipe[2].v;
        if (pipe[2].v) begin
            m_dout = pipe[2].d;
            m_err  = pipe[2].e;
            m_fail = pipe[2].f;
        end
        #1;
        check_all();
    endtask

    task automatic bubble(input int n, input logic clr);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, clr, clr);
    endtask

    initial begin
        logic [SW-1:0] m2;
        int a, b;
        arst = 1'b1; din_valid = 1'b0; din = '0; cnt_clear = 1'b0; cnt_clear_4 = 1'b0;
`ifdef ECC_SECDED_ERR_INJECT_EN
        inj_mask = '0;
`endif
        model_reset();
        ph = "reset";
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;

        ph = "zero_cw";
        step(1'b1, '0, '0, '0, 1'b0, 1'b0);
        bubble(2, 1'b0);
        chk("lat3_valid", 64'(dout_valid), 64'd1);
        bubble(2, 1'b0);

        ph = "clean_rand";
        for (int i = 0; i < 500; i++) step(1'b1, rand_pay(), '0, '0, 1'b0, 1'b0);
        bubble(4, 1'b0);
        chk("clean_corr", 64'(corr_cnt), 64'd0);

        ph = "walk1";
        bubble(1, 1'b1);
        for (int i = 0; i < SW; i++) begin
            step(1'b1, rand_pay(), bit_mask(i), '0, 1'b0, 1'b0);
            if (i % 7 == 3) bubble(1, 1'b0);
        end
        bubble(4, 1'b0);
        chk("walk_corr40", 64'(corr_cnt), 64'd40);
        chk("walk_fail0", 64'(fail_cnt), 64'd0);

        ph = "double";
        bubble(1, 1'b1);
        step(1'b1, '0, 40'h3, '0, 1'b0, 1'b0);
        for (int k = 0; k < 500; k++) begin
            a  = k % SW;
            b  = (a + 1 + (k / SW) % (SW - 1)) % SW;
            m2 = bit_mask(a) | bit_mask(b);
            step(1'b1, (k % 3 == 0) ? rand_pay() : '0, m2, '0, 1'b0, 1'b0);
        end
        bubble(4, 1'b0);
        chk("dbl_fail501", 64'(fail_cnt), 64'd501);
        chk("dbl_corr0", 64'(corr_cnt), 64'd0);

        ph = "sat4";
        bubble(1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, rand_pay(), bit_mask($urandom_range(SW - 1, 0)), '0, 1'b0, 1'b0);
        bubble(4, 1'b0);
        chk("sat_corr4", 64'(corr_cnt_4), 64'hF);
        chk("sat_corr16", 64'(corr_cnt), 64'd20);
        step(1'b1, rand_pay(), bit_mask(5), '0, 1'b0, 1'b1);
        bubble(2, 1'b0);
        chk("pre_clr_err", 64'(dout_err_4), 64'd1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("clr_wins", 64'(corr_cnt_4), 64'd0);
        chk("clr_other", 64'(corr_cnt), 64'd21);
        bubble(2, 1'b0);

        ph = "arst";
        for (int i = 0; i < 3; i++) step(1'b1, rand_pay(), bit_mask(i + 2), '0, 1'b0, 1'b0);
        din_valid = 1'b0;
        arst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        bubble(4, 1'b0);
        step(1'b1, rand_pay(), '0, '0, 1'b0, 1'b0);
        bubble(1, 1'b0);
        chk("post_rst_early", 64'(dout_valid), 64'd0);
        bubble(3, 1'b0);

`ifdef ECC_SECDED_ERR_INJECT_EN
        ph = "inject";
        bubble(1, 1'b1);
        step(1'b1, rand_pay(), '0, 40'h10, 1'b0, 1'b0);
        bubble(2, 1'b0);
        chk("inj_err", 64'(dout_err), 64'd1);
        bubble(2, 1'b0);
        chk("inj_corr1", 64'(corr_cnt), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
